// File: rtl/ldl_fifo_rs_v1_if.sv
// Read-side bus of the synchronous FIFO: consumer handshake, pointer exchange
// with the write side and the read port of the dual-port RAM.
// The slave modport is the read-side block; the master modport is everything
// around it (consumer, write-side pointer block and RAM).
interface ldl_fifo_rs_v1_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          re;
    logic          empty;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic [AW:0]   w_pt;
    logic [AW:0]   r_pt;
    logic [AW-1:0] ra;
    logic          mr;
    logic [DW-1:0] md;
    logic [AW+1:0] rcnt;
    logic          uflow;

    modport master (
        output re, w_pt, md,
        input  empty, dout, dout_vld, r_pt, ra, mr, rcnt, uflow
    );

    modport slave (
        input  re, w_pt, md,
        output empty, dout, dout_vld, r_pt, ra, mr, rcnt, uflow
    );
endinterface

// File: rtl/ldl_fifo_rs_v1.sv
// Read side of the synchronous FIFO. Owns the read pointer, drives the RAM
// read port (1-cycle synchronous read) and presents data to the consumer.
//   AHEAD=1: show-ahead; a 2-entry prefetch buffer keeps the head word valid
//            whenever empty is low, sustaining one word per cycle.
//   AHEAD=0: normal read; data and dout_vld arrive the cycle after re.
// Optional feature: define LDL_FIFO_RS_UFLOW_EN to build the sticky underflow
// flag; otherwise uflow is tied low.
module ldl_fifo_rs_v1 #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int AHEAD = 1
) (
    input  logic            clk,
    input  logic            rst,
    ldl_fifo_rs_v1_if.slave bus
);
    localparam logic [AW:0] PT_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_rpt;
    logic          w_mem_avail;
    logic          w_mr;
    logic          w_empty;
    logic          w_dout_vld;
    logic [DW-1:0] w_dout;
    logic [AW+1:0] w_rcnt;
    logic          w_uflow;

    // Words remain in the RAM whenever the two pointers differ (MSB breaks the full/empty tie).
    assign w_mem_avail = (bus.w_pt != r_rpt);

    // Read pointer advances once per RAM read issued; MSB toggles on wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_rpt <= '0;
        end else if (w_mr) begin
            r_rpt <= r_rpt + PT_ONE;
        end
    end

    if (AHEAD == 0) begin : g_normal
        logic          r_pend;
        logic [DW-1:0] r_dout;

        assign w_empty = ~w_mem_avail;
        assign w_mr    = bus.re & w_mem_avail;

        // Track the read in flight and hold the last returned word for the consumer.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pend <= 1'b0;
                r_dout <= '0;
            end else begin
                r_pend <= w_mr;
                if (r_pend) begin
                    r_dout <= bus.md;
                end
            end
        end

        // md is already the RAM's registered output: show it on the return cycle, hold it afterwards.
        assign w_dout     = r_pend ? bus.md : r_dout;
        assign w_dout_vld = r_pend;
        assign w_rcnt     = {1'b0, bus.w_pt - r_rpt};
    end else begin : g_ahead
        logic [DW-1:0] r_buf [2];
        logic          r_hd;
        logic [1:0]    r_occ;
        logic          r_pend;
        logic          w_pop;
        logic          w_tail;
        logic [2:0]    w_occ_sum;

        assign w_pop     = bus.re & (r_occ != 2'd0);
        // Occupancy the buffer will have once the in-flight word lands and this pop leaves.
        assign w_occ_sum = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
        assign w_mr      = w_mem_avail & (w_occ_sum < 3'd2);
        // Tail slot is judged against the pre-pop head; with occ==1 and a pop it becomes the new head.
        assign w_tail    = r_hd ^ r_occ[0];

        // Prefetch buffer: fill the tail from the RAM return, advance the head on pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: the two buffer words are reset so dout reads zero straight out of reset.
                r_buf[0] <= '0;
                r_buf[1] <= '0;
                r_hd     <= 1'b0;
                r_occ    <= 2'd0;
                r_pend   <= 1'b0;
            end else begin
                r_pend <= w_mr;
                r_occ  <= w_occ_sum[1:0];
                r_hd   <= r_hd ^ w_pop;
                if (r_pend) begin
                    r_buf[w_tail] <= bus.md;
                end
            end
        end

        // Fetch throttling must keep buffered plus in-flight words within the two slots.
        assert property (@(posedge clk) disable iff (rst) w_occ_sum <= 3'd2);

        assign w_empty    = (r_occ == 2'd0);
        assign w_dout     = r_buf[r_hd];
        assign w_dout_vld = ~w_empty;
        assign w_rcnt     = {1'b0, bus.w_pt - r_rpt} + {{AW{1'b0}}, r_occ}
                          + {{(AW+1){1'b0}}, r_pend};
    end

`ifdef LDL_FIFO_RS_UFLOW_EN
    logic r_uflow;

    // Sticky record of any read attempted against an empty FIFO; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_uflow <= 1'b0;
        end else if (bus.re & w_empty) begin
            r_uflow <= 1'b1;
        end
    end

    assign w_uflow = r_uflow;
`else
    assign w_uflow = 1'b0;
`endif

    assign bus.empty    = w_empty;
    assign bus.dout     = w_dout;
    assign bus.dout_vld = w_dout_vld;
    assign bus.r_pt     = r_rpt;
    assign bus.ra       = r_rpt[AW-1:0];
    assign bus.mr       = w_mr;
    assign bus.rcnt     = w_rcnt;
    assign bus.uflow    = w_uflow;
endmodule

// File: tb/tb_ldl_fifo_rs_v1.sv
// Directed bench for ldl_fifo_rs_v1: one show-ahead instance and one
// normal-read instance (both AW=3), each with its own small RAM model and
// write-side pointer driven from the stimulus tasks.
module tb_ldl_fifo_rs_v1;
    localparam int AW = 3;
    localparam int DW = 32;

`ifdef LDL_FIFO_RS_UFLOW_EN
    localparam logic EXP_UFLOW = 1'b1;
`else
    localparam logic EXP_UFLOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] mem_a1 [8];
    logic [DW-1:0] mem_a0 [8];

    always #5 clk = ~clk;

    ldl_fifo_rs_v1_if #(.AW(AW), .DW(DW)) if_a1 ();
    ldl_fifo_rs_v1_if #(.AW(AW), .DW(DW)) if_a0 ();

    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(1)) u_dut_a1 (
        .clk (clk),
        .rst (rst),
        .bus (if_a1)
    );

    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(0)) u_dut_a0 (
        .clk (clk),
        .rst (rst),
        .bus (if_a0)
    );

    // RAM models: 1-cycle synchronous read.
    always @(posedge clk) begin
        if (if_a1.mr === 1'b1) if_a1.md <= mem_a1[if_a1.ra];
        if (if_a0.mr === 1'b1) if_a0.md <= mem_a0[if_a0.ra];
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if_a1.re = 1'b0;
        if_a0.re = 1'b0;
        if_a1.w_pt = '0;
        if_a0.w_pt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (if_a1.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", if_a1.empty); end
        n_cmp++; if (if_a1.r_pt !== 4'd0) begin n_err++; $display("FAIL reset_r_pt: got %h want 0", if_a1.r_pt); end
        n_cmp++; if (if_a1.mr !== 1'b0) begin n_err++; $display("FAIL reset_mr: got %b want 0", if_a1.mr); end
        n_cmp++; if (if_a1.rcnt !== 5'd0) begin n_err++; $display("FAIL reset_rcnt: got %0d want 0", if_a1.rcnt); end
        n_cmp++; if (if_a1.dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", if_a1.dout); end
        n_cmp++; if (if_a1.dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_dout_vld: got %b want 0", if_a1.dout_vld); end
        n_cmp++; if (if_a1.uflow !== 1'b0) begin n_err++; $display("FAIL reset_uflow: got %b want 0", if_a1.uflow); end
        n_cmp++; if (if_a0.empty !== 1'b1) begin n_err++; $display("FAIL reset_a0_empty: got %b want 1", if_a0.empty); end
        n_cmp++; if (if_a0.dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_a0_dout_vld: got %b want 0", if_a0.dout_vld); end
        n_cmp++; if (if_a0.dout !== 32'h0) begin n_err++; $display("FAIL reset_a0_dout: got %h want 0", if_a0.dout); end
    endtask

    task automatic test_single_write();
        // cycle N: first word becomes visible to the read side
        @(negedge clk);
        mem_a1[0] = 32'h11;
        if_a1.w_pt = 4'd1;
        #1;
        n_cmp++; if (if_a1.mr !== 1'b1) begin n_err++; $display("FAIL single_mr_n: got %b want 1", if_a1.mr); end
        n_cmp++; if (if_a1.ra !== 3'd0) begin n_err++; $display("FAIL single_ra_n: got %0d want 0", if_a1.ra); end
        n_cmp++; if (if_a1.empty !== 1'b1) begin n_err++; $display("FAIL single_empty_n: got %b want 1", if_a1.empty); end
        n_cmp++; if (if_a1.rcnt !== 5'd1) begin n_err++; $display("FAIL single_rcnt_n: got %0d want 1", if_a1.rcnt); end
        // cycle N+1: word in flight
        @(negedge clk);
        #1;
        n_cmp++; if (if_a1.empty !== 1'b1) begin n_err++; $display("FAIL single_empty_n1: got %b want 1", if_a1.empty); end
        n_cmp++; if (if_a1.mr !== 1'b0) begin n_err++; $display("FAIL single_mr_n1: got %b want 0", if_a1.mr); end
        n_cmp++; if (if_a1.rcnt !== 5'd1) begin n_err++; $display("FAIL single_rcnt_n1: got %0d want 1", if_a1.rcnt); end
        // cycle N+2: head valid, then popped
        @(negedge clk);
        #1;
        n_cmp++; if (if_a1.empty !== 1'b0) begin n_err++; $display("FAIL single_empty_n2: got %b want 0", if_a1.empty); end
        n_cmp++; if (if_a1.dout !== 32'h11) begin n_err++; $display("FAIL single_dout_n2: got %h want 11", if_a1.dout); end
        n_cmp++; if (if_a1.dout_vld !== 1'b1) begin n_err++; $display("FAIL single_vld_n2: got %b want 1", if_a1.dout_vld); end
        n_cmp++; if (if_a1.rcnt !== 5'd1) begin n_err++; $display("FAIL single_rcnt_n2: got %0d want 1", if_a1.rcnt); end
        if_a1.re = 1'b1;
        #1;
        n_cmp++; if (if_a1.mr !== 1'b0) begin n_err++; $display("FAIL single_mr_pop: got %b want 0", if_a1.mr); end
        @(negedge clk);
        if_a1.re = 1'b0;
        #1;
        n_cmp++; if (if_a1.empty !== 1'b1) begin n_err++; $display("FAIL single_empty_after: got %b want 1", if_a1.empty); end
        n_cmp++; if (if_a1.rcnt !== 5'd0) begin n_err++; $display("FAIL single_rcnt_after: got %0d want 0", if_a1.rcnt); end
        n_cmp++; if (if_a1.r_pt !== 4'd1) begin n_err++; $display("FAIL single_r_pt_after: got %0d want 1", if_a1.r_pt); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_a1[i] = 32'(i);
            if_a1.w_pt = 4'(i + 1);
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (if_a1.rcnt !== 5'd8) begin n_err++; $display("FAIL stream_rcnt_full: got %0d want 8", if_a1.rcnt); end
        n_cmp++; if (if_a1.r_pt !== 4'd2) begin n_err++; $display("FAIL stream_r_pt_prefetch: got %0d want 2", if_a1.r_pt); end
        n_cmp++; if (if_a1.dout !== 32'd0) begin n_err++; $display("FAIL stream_head: got %h want 0", if_a1.dout); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if_a1.re = 1'b1;
            #1;
            n_cmp++; if (if_a1.empty !== 1'b0) begin n_err++; $display("FAIL stream_empty[%0d]: got %b want 0", i, if_a1.empty); end
            n_cmp++; if (if_a1.dout !== 32'(i)) begin n_err++; $display("FAIL stream_dout[%0d]: got %h want %h", i, if_a1.dout, 32'(i)); end
        end
        @(negedge clk);
        if_a1.re = 1'b0;
        #1;
        n_cmp++; if (if_a1.empty !== 1'b1) begin n_err++; $display("FAIL stream_empty_end: got %b want 1", if_a1.empty); end
        n_cmp++; if (if_a1.r_pt !== 4'd8) begin n_err++; $display("FAIL stream_r_pt_end: got %0d want 8", if_a1.r_pt); end
        n_cmp++; if (if_a1.rcnt !== 5'd0) begin n_err++; $display("FAIL stream_rcnt_end: got %0d want 0", if_a1.rcnt); end
    endtask

    task automatic test_normal_read();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_a0[i] = 32'hA0 + 32'(i);
            if_a0.w_pt = 4'(i + 1);
        end
        #1;
        n_cmp++; if (if_a0.rcnt !== 5'd3) begin n_err++; $display("FAIL normal_rcnt: got %0d want 3", if_a0.rcnt); end
        n_cmp++; if (if_a0.empty !== 1'b0) begin n_err++; $display("FAIL normal_empty: got %b want 0", if_a0.empty); end
        // R0: first pop issued
        @(negedge clk);
        if_a0.re = 1'b1;
        #1;
        n_cmp++; if (if_a0.mr !== 1'b1) begin n_err++; $display("FAIL normal_mr0: got %b want 1", if_a0.mr); end
        n_cmp++; if (if_a0.ra !== 3'd0) begin n_err++; $display("FAIL normal_ra0: got %0d want 0", if_a0.ra); end
        n_cmp++; if (if_a0.dout_vld !== 1'b0) begin n_err++; $display("FAIL normal_vld0: got %b want 0", if_a0.dout_vld); end
        // R1, R2: data of the previous pop returns while the next pop issues
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (if_a0.dout_vld !== 1'b1) begin n_err++; $display("FAIL normal_vld%0d: got %b want 1", i, if_a0.dout_vld); end
            n_cmp++; if (if_a0.dout !== 32'hA0 + 32'(i - 1)) begin n_err++; $display("FAIL normal_dout%0d: got %h want %h", i, if_a0.dout, 32'hA0 + 32'(i - 1)); end
            n_cmp++; if (if_a0.mr !== 1'b1) begin n_err++; $display("FAIL normal_mr%0d: got %b want 1", i, if_a0.mr); end
            n_cmp++; if (if_a0.ra !== 3'(i)) begin n_err++; $display("FAIL normal_ra%0d: got %0d want %0d", i, if_a0.ra, i); end
        end
        // R3: fourth re against an empty FIFO
        @(negedge clk);
        #1;
        n_cmp++; if (if_a0.empty !== 1'b1) begin n_err++; $display("FAIL normal_empty3: got %b want 1", if_a0.empty); end
        n_cmp++; if (if_a0.mr !== 1'b0) begin n_err++; $display("FAIL normal_mr3: got %b want 0", if_a0.mr); end
        n_cmp++; if (if_a0.dout_vld !== 1'b1) begin n_err++; $display("FAIL normal_vld3: got %b want 1", if_a0.dout_vld); end
        n_cmp++; if (if_a0.dout !== 32'hA2) begin n_err++; $display("FAIL normal_dout3: got %h want a2", if_a0.dout); end
        // R4: ignored re produced no data
        @(negedge clk);
        if_a0.re = 1'b0;
        #1;
        n_cmp++; if (if_a0.dout_vld !== 1'b0) begin n_err++; $display("FAIL normal_vld4: got %b want 0", if_a0.dout_vld); end
        n_cmp++; if (if_a0.dout !== 32'hA2) begin n_err++; $display("FAIL normal_dout_hold: got %h want a2", if_a0.dout); end
        n_cmp++; if (if_a0.r_pt !== 4'd3) begin n_err++; $display("FAIL normal_r_pt: got %0d want 3", if_a0.r_pt); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_word;
        int   wcnt = 0;
        int   pcnt = 0;
        int   wraps = 0;
        int   c = 0;
        bit   wrap_pend = 1'b0;
        logic saved_msb = 1'b0;
        do_reset();
        while (pcnt < 20 && c < 300) begin
            @(negedge clk);
            if (wrap_pend) begin
                n_cmp++; if (if_a1.r_pt !== {~saved_msb, 3'b000}) begin n_err++; $display("FAIL wrap_msb: got %b want %b000", if_a1.r_pt, ~saved_msb); end
                wraps++;
                wrap_pend = 1'b0;
            end
            if (wcnt < 20 && (wcnt - pcnt) < 8 && (c % 5) != 4) begin
                mem_a1[wcnt % 8] = 32'h100 + 32'(wcnt);
                q.push_back(32'h100 + 32'(wcnt));
                wcnt++;
                if_a1.w_pt = 4'(wcnt);
            end
            if_a1.re = ((c % 3) != 2);
            #1;
            n_cmp++; if (if_a1.rcnt !== 5'(wcnt - pcnt)) begin n_err++; $display("FAIL wrap_rcnt c%0d: got %0d want %0d", c, if_a1.rcnt, wcnt - pcnt); end
            if (if_a1.empty === 1'b0 && wcnt == pcnt) begin
                n_err++; n_cmp++;
                $display("FAIL wrap_phantom c%0d: empty low with no word written", c);
            end
            if (if_a1.mr === 1'b1 && if_a1.ra === 3'd7) begin
                wrap_pend = 1'b1;
                saved_msb = if_a1.r_pt[3];
            end
            if (if_a1.re && if_a1.empty === 1'b0) begin
                exp_word = q.pop_front();
                n_cmp++; if (if_a1.dout !== exp_word) begin n_err++; $display("FAIL wrap_dout p%0d: got %h want %h", pcnt, if_a1.dout, exp_word); end
                pcnt++;
            end
            c++;
        end
        @(negedge clk);
        if_a1.re = 1'b0;
        n_cmp++; if (pcnt != 20) begin n_err++; $display("FAIL wrap_timeout: popped %0d want 20", pcnt); end
        n_cmp++; if (wraps != 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", wraps); end
        n_cmp++; if (if_a1.r_pt !== 4'd4) begin n_err++; $display("FAIL wrap_r_pt_end: got %0d want 4", if_a1.r_pt); end
    endtask

    task automatic test_uflow();
        do_reset();
        @(negedge clk);
        if_a1.re = 1'b1;
        #1;
        n_cmp++; if (if_a1.mr !== 1'b0) begin n_err++; $display("FAIL uflow_mr_empty: got %b want 0", if_a1.mr); end
        @(negedge clk);
        if_a1.re = 1'b0;
        #1;
        n_cmp++; if (if_a1.uflow !== EXP_UFLOW) begin n_err++; $display("FAIL uflow_set: got %b want %b", if_a1.uflow, EXP_UFLOW); end
        n_cmp++; if (if_a1.r_pt !== 4'd0) begin n_err++; $display("FAIL uflow_r_pt_hold: got %0d want 0", if_a1.r_pt); end
        @(negedge clk);
        mem_a1[0] = 32'h55;
        if_a1.w_pt = 4'd1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (if_a1.dout !== 32'h55) begin n_err++; $display("FAIL uflow_dout: got %h want 55", if_a1.dout); end
        if_a1.re = 1'b1;
        @(negedge clk);
        if_a1.re = 1'b0;
        #1;
        n_cmp++; if (if_a1.uflow !== EXP_UFLOW) begin n_err++; $display("FAIL uflow_sticky: got %b want %b", if_a1.uflow, EXP_UFLOW); end
        n_cmp++; if (if_a1.r_pt !== 4'd1) begin n_err++; $display("FAIL uflow_r_pt_read: got %0d want 1", if_a1.r_pt); end
        do_reset();
        #1;
        n_cmp++; if (if_a1.uflow !== 1'b0) begin n_err++; $display("FAIL uflow_clear: got %b want 0", if_a1.uflow); end
    endtask

    initial begin
        rst = 1'b1;
        if_a1.re = 1'b0;
        if_a0.re = 1'b0;
        if_a1.w_pt = '0;
        if_a0.w_pt = '0;
        if_a1.md = '0;
        if_a0.md = '0;
        test_reset();
        test_single_write();
        test_stream();
        test_normal_read();
        test_wrap();
        test_uflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
